vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_pix_tick.sv | 35 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 default timing, sync polarity and raster state types.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_CLK_DIV  = 4;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  // PREROLL covers the partial pixel period right after reset release.
  typedef enum logic {
    ST_PREROLL = 1'b0,
    ST_RUN     = 1'b1
  } raster_state_e;

  // Pin level for a sync output given whether the pulse window is active.
  function automatic logic sync_level(input logic active, input sync_pol_e pol);
    return (pol == SYNC_ACTIVE_HIGH) ? active : ~active;
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: one-clk tick per pixel period plus a divided pixel clock.
module vga_pix_tick
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic pix_clk_out
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  // Tick on the last count of the period; the counter wraps there.
  always_comb begin
    tick     = (div == DW'(CLK_DIV - 1));
    div_next = tick ? '0 : div + DW'(1);
  end

  // pix_clk_out is registered from the next count so it tracks div exactly yet resets low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pix_clk_out <= 1'b0;
    end else begin
      div         <= div_next;
      pix_clk_out <= (div_next < DW'(CLK_DIV / 2));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, sync generation and a one-pixel colour pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [COLOR_W-1:0]                                 r_in,
  input  logic [COLOR_W-1:0]                                 g_in,
  input  logic [COLOR_W-1:0]                                 b_in,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       pix_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       pix_y,
  output logic                                               pix_req,
  output logic                                               hsync,
  output logic                                               vsync,
  output logic                                               de,
  output logic [COLOR_W-1:0]                                 r_out,
  output logic [COLOR_W-1:0]                                 g_out,
  output logic [COLOR_W-1:0]                                 b_out,
  output logic                                               pix_clk_out,
  output logic                                               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);

  localparam sync_pol_e HPOL = HSYNC_POL ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
  localparam sync_pol_e VPOL = VSYNC_POL ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;

  logic          tick;
  logic          x_last;
  logic          y_last;
  logic          h_win;
  logic          v_win;
  raster_state_e state;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .pix_clk_out (pix_clk_out)
  );

  // Position decodes for the current raster coordinate.
  always_comb begin
    x_last  = (pix_x == XW'(H_TOTAL - 1));
    y_last  = (pix_y == YW'(V_TOTAL - 1));
    pix_req = (pix_x < XW'(H_ACTIVE)) && (pix_y < YW'(V_ACTIVE));
    h_win   = (pix_x >= XW'(H_ACTIVE + H_FP)) && (pix_x <= XW'(H_ACTIVE + H_FP + H_SYNC - 1));
    v_win   = (pix_y >= YW'(V_ACTIVE + V_FP)) && (pix_y <= YW'(V_ACTIVE + V_FP + V_SYNC - 1));
  end

  // Raster counters; the first tick after reset only starts the frame at (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PREROLL;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        if (state == ST_PREROLL) begin
          state       <= ST_RUN;
          frame_start <= 1'b1;
        end else if (x_last) begin
          pix_x <= '0;
          if (y_last) begin
            pix_y       <= '0;
            frame_start <= 1'b1;
          end else begin
            pix_y <= pix_y + YW'(1);
          end
        end else begin
          pix_x <= pix_x + XW'(1);
        end
      end
    end
  end

  // One-pixel output pipeline: colour, de and syncs for the pixel just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de    <= 1'b0;
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
      hsync <= sync_level(1'b0, HPOL);
      vsync <= sync_level(1'b0, VPOL);
    end else if (tick) begin
      if (state == ST_PREROLL) begin
        de    <= 1'b0;
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
        hsync <= sync_level(1'b0, HPOL);
        vsync <= sync_level(1'b0, VPOL);
      end else begin
        de    <= pix_req;
        r_out <= pix_req ? r_in : '0;
        g_out <= pix_req ? g_in : '0;
        b_out <= pix_req ? b_in : '0;
        hsync <= sync_level(h_win, HPOL);
        vsync <= sync_level(v_win, VPOL);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a small raster (H 4/1/2/1, V 3/1/1/1, CLK_DIV 2).
module tb_vga_timing_gen;

  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned CD = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned XW = $clog2(HT);
  localparam int unsigned YW = $clog2(VT);

  typedef struct packed {
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hact;
    logic       vact;
  } vid_t;

  logic clk;
  logic rst_n;
  logic [7:0] r_in, g_in, b_in;

  logic [XW-1:0] pix_x, i_pix_x;
  logic [YW-1:0] pix_y, i_pix_y;
  logic pix_req, hsync, vsync, de, pix_clk_out, frame_start;
  logic i_pix_req, i_hsync, i_vsync, i_de, i_pix_clk_out, i_frame_start;
  logic [7:0] r_out, g_out, b_out, i_r_out, i_g_out, i_b_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_div, m_x, m_y;
  bit          m_run, m_fs;
  vid_t        sb[$];
  vid_t        cur;

  // Measurement state
  int clk_cnt, last_fs, de_cnt, de_rise, hs_fall, vs_fall;
  bit seen_fs;
  logic prev_de, prev_hs, prev_vs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen #(
    .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .hsync(hsync), .vsync(vsync),
    .de(de), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .pix_clk_out(pix_clk_out), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_x(i_pix_x), .pix_y(i_pix_y), .pix_req(i_pix_req), .hsync(i_hsync), .vsync(i_vsync),
    .de(i_de), .r_out(i_r_out), .g_out(i_g_out), .b_out(i_b_out),
    .pix_clk_out(i_pix_clk_out), .frame_start(i_frame_start)
  );

  task automatic model_reset();
    m_div = 0; m_x = 0; m_y = 0; m_run = 1'b0; m_fs = 1'b0;
    sb.delete();
    cur = '0;
    clk_cnt = 0; last_fs = -1; de_cnt = 0; de_rise = -1; hs_fall = -1; vs_fall = -1;
    seen_fs = 1'b0;
    prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  // Runs n clocks; mode 0 drives r_in=A5, mode 1 drives r_in=current x.
  task automatic run_cycles(input int unsigned n, input int unsigned mode);
    for (int unsigned i = 0; i < n; i++) begin
      vid_t e;
      bit   req;
      r_in = (mode == 0) ? 8'hA5 : 8'(m_x);
      g_in = ~r_in;
      b_in = 8'h3C ^ 8'(m_y);
      @(posedge clk);
      clk_cnt++;
      m_fs = 1'b0;
      if (m_div == CD - 1) begin
        e = '0;
        if (!m_run) begin
          m_run = 1'b1;
          m_fs  = 1'b1;
        end else begin
          req    = (m_x < HA) && (m_y < VA);
          e.de   = req;
          e.r    = req ? r_in : 8'h00;
          e.g    = req ? g_in : 8'h00;
          e.b    = req ? b_in : 8'h00;
          e.hact = (m_x >= HA + HF) && (m_x < HA + HF + HS);
          e.vact = (m_y >= VA + VF) && (m_y < VA + VF + VS);
          if (m_x == HT - 1) begin
            m_x = 0;
            if (m_y == VT - 1) begin
              m_y  = 0;
              m_fs = 1'b1;
            end else begin
              m_y++;
            end
          end else begin
            m_x++;
          end
        end
        sb.push_back(e);
      end
      m_div = (m_div == CD - 1) ? 0 : m_div + 1;
      @(negedge clk);
      if (sb.size() > 0) cur = sb.pop_front();

      checks++;
      if ({pix_x, pix_y} !== {XW'(m_x), YW'(m_y)}) begin
        errors++;
        $display("FAIL coord t=%0t: got x=%0d y=%0d, want x=%0d y=%0d", $time, pix_x, pix_y, m_x, m_y);
      end
      checks++;
      if (pix_req !== ((m_x < HA) && (m_y < VA))) begin
        errors++;
        $display("FAIL pix_req t=%0t: got %b, want %b", $time, pix_req, (m_x < HA) && (m_y < VA));
      end
      checks++;
      if (pix_clk_out !== (m_div < CD / 2)) begin
        errors++;
        $display("FAIL pix_clk_out t=%0t: got %b, want %b", $time, pix_clk_out, m_div < CD / 2);
      end
      checks++;
      if (frame_start !== m_fs) begin
        errors++;
        $display("FAIL frame_start t=%0t: got %b, want %b", $time, frame_start, m_fs);
      end
      checks++;
      if ({de, r_out, g_out, b_out} !== {cur.de, cur.r, cur.g, cur.b}) begin
        errors++;
        $display("FAIL video t=%0t: got de=%b rgb=%h/%h/%h, want de=%b rgb=%h/%h/%h",
                 $time, de, r_out, g_out, b_out, cur.de, cur.r, cur.g, cur.b);
      end
      checks++;
      if ({hsync, vsync} !== {~cur.hact, ~cur.vact}) begin
        errors++;
        $display("FAIL sync t=%0t: got hs=%b vs=%b, want hs=%b vs=%b",
                 $time, hsync, vsync, ~cur.hact, ~cur.vact);
      end
      checks++;
      if ({i_hsync, i_vsync, i_de, i_r_out} !== {cur.hact, cur.vact, cur.de, cur.r}) begin
        errors++;
        $display("FAIL inv_pol t=%0t: got hs=%b vs=%b de=%b r=%h, want hs=%b vs=%b de=%b r=%h",
                 $time, i_hsync, i_vsync, i_de, i_r_out, cur.hact, cur.vact, cur.de, cur.r);
      end

      if (frame_start) begin
        if (!seen_fs) begin
          checks++;
          if (clk_cnt != 2) begin
            errors++;
            $display("FAIL first_fs: got %0d clks after release, want 2", clk_cnt);
          end
          seen_fs = 1'b1;
        end
        if (last_fs >= 0) begin
          checks++;
          if (clk_cnt - last_fs != 96) begin
            errors++;
            $display("FAIL fs_period: got %0d clks, want 96", clk_cnt - last_fs);
          end
          checks++;
          if (de_cnt != 24) begin
            errors++;
            $display("FAIL de_per_frame: got %0d clks, want 24", de_cnt);
          end
        end
        last_fs = clk_cnt;
        de_cnt  = 0;
      end
      if (de === 1'b1) de_cnt++;
      if (de && !prev_de) de_rise = clk_cnt;
      if (!hsync && prev_hs) begin
        if (de_rise >= 0) begin
          checks++;
          if (clk_cnt - de_rise != 5 * CD) begin
            errors++;
            $display("FAIL hs_offset: got %0d clks after de rise, want %0d", clk_cnt - de_rise, 5 * CD);
          end
          de_rise = -1;
        end
        hs_fall = clk_cnt;
      end
      if (hsync && !prev_hs && hs_fall >= 0) begin
        checks++;
        if (clk_cnt - hs_fall != HS * CD) begin
          errors++;
          $display("FAIL hs_width: got %0d clks, want %0d", clk_cnt - hs_fall, HS * CD);
        end
      end
      if (!vsync && prev_vs) vs_fall = clk_cnt;
      if (vsync && !prev_vs && vs_fall >= 0) begin
        checks++;
        if (clk_cnt - vs_fall != HT * CD) begin
          errors++;
          $display("FAIL vs_width: got %0d clks, want %0d", clk_cnt - vs_fall, HT * CD);
        end
      end
      prev_de = de;
      prev_hs = hsync;
      prev_vs = vsync;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix_x, pix_y, de, r_out, g_out, b_out, frame_start, pix_clk_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d de=%b rgb=%h/%h/%h fs=%b pclk=%b, want all 0",
               pix_x, pix_y, de, r_out, g_out, b_out, frame_start, pix_clk_out);
    end
    checks++;
    if ({hsync, vsync, i_hsync, i_vsync} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_sync: got %b%b%b%b, want 1100", hsync, vsync, i_hsync, i_vsync);
    end
  endtask

  task automatic test_raster_const();
    release_reset();
    run_cycles(2 * 96 + 4, 0);
  endtask

  task automatic test_ramp();
    run_cycles(96, 1);
  endtask

  task automatic test_async_reset();
    int unsigned guard = 0;
    while (!(m_x == 5 && m_y == 2) && guard < 200) begin
      run_cycles(1, 1);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL reach_5_2: got x=%0d y=%0d, want 5 2", m_x, m_y);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_x, pix_y, de, r_out, g_out, b_out, frame_start, pix_clk_out} !== '0) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d de=%b rgb=%h/%h/%h fs=%b pclk=%b, want all 0",
               pix_x, pix_y, de, r_out, g_out, b_out, frame_start, pix_clk_out);
    end
    checks++;
    if ({hsync, vsync, i_hsync, i_vsync} !== 4'b1100) begin
      errors++;
      $display("FAIL async_reset_sync: got %b%b%b%b, want 1100", hsync, vsync, i_hsync, i_vsync);
    end
    repeat (3) @(negedge clk);
    release_reset();
    run_cycles(96 + 4, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raster_const();
    test_ramp();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
